// File: rtl/cart_mapper_pkg.sv
// Shared types and constants for the MSX cartridge bank mapper.
package cart_mapper_pkg;

  typedef enum logic [1:0] {
    ModeKonami    = 2'd0,
    ModeKonamiScc = 2'd1,
    ModeAscii8    = 2'd2,
    ModeAscii16   = 2'd3
  } mapper_mode_t;

  localparam logic [15:0] PageBaseLo = 16'h4000;
  localparam logic [15:0] PageBaseHi = 16'h8000;

  // Konami schemes start with an identity bank layout; ASCII schemes start all-zero.
  function automatic logic [1:0] bank_reset_val(input mapper_mode_t mode, input logic [1:0] idx);
    return (mode == ModeKonami || mode == ModeKonamiScc) ? idx : 2'd0;
  endfunction

  function automatic logic is_ascii(input mapper_mode_t mode);
    return (mode == ModeAscii8) || (mode == ModeAscii16);
  endfunction

endpackage

// File: rtl/cart_bank_decode.sv
// Bank register write-window decode: (mode, addr[15:11]) -> hit and bank index.
module cart_bank_decode
  import cart_mapper_pkg::*;
(
  input  mapper_mode_t mode,
  input  logic [4:0]   addr_hi,
  output logic         hit,
  output logic [1:0]   idx
);

  always_comb begin
    hit = 1'b0;
    idx = 2'd0;
    case (mode)
      ModeKonami: begin
        // 8K-wide windows; bank 0 is not writable
        case (addr_hi[4:2])
          3'b011:  begin hit = 1'b1; idx = 2'd1; end
          3'b100:  begin hit = 1'b1; idx = 2'd2; end
          3'b101:  begin hit = 1'b1; idx = 2'd3; end
          default: ;
        endcase
      end
      ModeKonamiScc: begin
        case (addr_hi)
          5'h0a:   begin hit = 1'b1; idx = 2'd0; end
          5'h0e:   begin hit = 1'b1; idx = 2'd1; end
          5'h12:   begin hit = 1'b1; idx = 2'd2; end
          5'h16:   begin hit = 1'b1; idx = 2'd3; end
          default: ;
        endcase
      end
      ModeAscii8: begin
        if (addr_hi[4:2] == 3'b011) begin
          hit = 1'b1;
          idx = addr_hi[1:0];
        end
      end
      ModeAscii16: begin
        case (addr_hi)
          5'h0c:   begin hit = 1'b1; idx = 2'd0; end
          5'h0e:   begin hit = 1'b1; idx = 2'd1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cart_bank_mapper.sv
// MSX ROM mapper for Konami, Konami-SCC, ASCII8 and ASCII16 bank switching.
// Define CART_BANK_SRAM_EN to map battery SRAM through bank bit BANK_W-1 in ASCII modes.
module cart_bank_mapper
  import cart_mapper_pkg::*;
#(
  parameter int unsigned BANK_W  = 8,
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned SRAM_AW = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               wr,
  input  logic               rd,
  input  logic [15:0]        addr,
  input  logic [7:0]         d_from_cpu,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  rom_size,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_oe,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we,
  output logic               sram_oe
);

  mapper_mode_t      mode_cur, mode_q;
  logic              mode_chg;
  logic              wr_q, wr_ev;
  logic              wr_hit;
  logic [1:0]        wr_idx;
  logic [ADDR_W-1:0] rom_mask_q;
  logic [BANK_W-1:0] bank_q [4];

  // Smear the top set bit of (size-1) downward; never smaller than one 8K page.
  function automatic logic [ADDR_W-1:0] calc_rom_mask(input logic [ADDR_W-1:0] size);
    logic [ADDR_W-1:0] m;
    m = size - ADDR_W'(1);
    for (int i = 0; i < int'(ADDR_W); i++) m = m | (m >> 1);
    m[12:0] = '1;
    return m;
  endfunction

  assign mode_cur = mapper_mode_t'(mode);
  assign mode_chg = (mode_q != mode_cur);
  assign wr_ev    = cs & wr & ~wr_q;

  cart_bank_decode u_decode (
    .mode    (mode_cur),
    .addr_hi (addr[15:11]),
    .hit     (wr_hit),
    .idx     (wr_idx)
  );

  always_ff @(posedge clk) begin
    // wr_q follows wr even through reset so a strobe spanning reset release
    // cannot produce a fresh edge; with an idle bus it resets to 0.
    wr_q   <= wr;
    mode_q <= mode_cur;
    if (reset) rom_mask_q <= calc_rom_mask(rom_size);
    if (reset || mode_chg) begin
      for (int i = 0; i < 4; i++) bank_q[i] <= BANK_W'(bank_reset_val(mode_cur, 2'(i)));
    end else if (wr_ev && wr_hit) begin
      bank_q[wr_idx] <= BANK_W'(d_from_cpu);
    end
  end

  logic                     in_range, ascii16, sram_sel;
  logic [1:0]               rd_idx;
  logic [BANK_W-1:0]        sel_bank;
  logic [ADDR_W+BANK_W+13:0] map_wide;
`ifdef CART_BANK_SRAM_EN
  logic [SRAM_AW+14:0]      sram_wide;
`endif

  always_comb begin
    in_range = (addr[15:14] == PageBaseLo[15:14]) || (addr[15:14] == PageBaseHi[15:14]);
    ascii16  = (mode_q == ModeAscii16);
    rd_idx   = ascii16 ? {1'b0, addr[15]} : (addr[14:13] - 2'd2);
    sel_bank = bank_q[rd_idx];
    map_wide = '0;
    if (ascii16) map_wide[BANK_W+13:0] = {sel_bank, addr[13:0]};
    else         map_wide[BANK_W+12:0] = {sel_bank, addr[12:0]};
`ifdef CART_BANK_SRAM_EN
    sram_sel  = in_range & is_ascii(mode_q) & sel_bank[BANK_W-1];
    sram_wide = '0;
    if (ascii16) sram_wide[14:0] = {sel_bank[0], addr[13:0]};
    else         sram_wide[14:0] = {sel_bank[1:0], addr[12:0]};
`else
    sram_sel = 1'b0;
`endif

    mem_addr  = '0;
    mem_oe    = 1'b0;
    sram_addr = '0;
    sram_we   = 1'b0;
    sram_oe   = 1'b0;
    if (!reset) begin
      if (in_range) mem_addr = map_wide[ADDR_W-1:0] & rom_mask_q;
      mem_oe = cs & rd & in_range & ~sram_sel;
`ifdef CART_BANK_SRAM_EN
      // Only the upper page may write SRAM; a lower-page SRAM window is read-only.
      sram_oe = cs & rd & sram_sel;
      sram_we = cs & wr & sram_sel & (addr[15:14] == PageBaseHi[15:14]);
      if (sram_sel) sram_addr = sram_wide[SRAM_AW-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed self-checking bench for cart_bank_mapper (default or CART_BANK_SRAM_EN build).
module tb_cart_bank_mapper;

  logic        clk = 1'b0;
  logic        reset, cs, wr, rd;
  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic [1:0]  mode;
  logic [24:0] rom_size, mem_addr;
  logic        mem_oe;
  logic [14:0] sram_addr;
  logic        sram_we, sram_oe;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  cart_bank_mapper #(.BANK_W(8), .ADDR_W(25), .SRAM_AW(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .wr         (wr),
    .rd         (rd),
    .addr       (addr),
    .d_from_cpu (d_from_cpu),
    .mode       (mode),
    .rom_size   (rom_size),
    .mem_addr   (mem_addr),
    .mem_oe     (mem_oe),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_oe    (sram_oe)
  );

  task automatic set_bus(input logic c, input logic w, input logic r, input logic [15:0] a,
                         input logic [7:0] d);
    cs = c; wr = w; rd = r; addr = a; d_from_cpu = d;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); set_bus(1'b1, 1'b1, 1'b0, a, d);
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic apply_reset(input logic [1:0] m, input logic [24:0] size);
    @(negedge clk); reset = 1'b1; mode = m; rom_size = size;
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic change_mode(input logic [1:0] m);
    @(negedge clk); mode = m;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1; mode = 2'd0; rom_size = 25'h20000;
    set_bus(1'b1, 1'b0, 1'b1, 16'h6000, 8'h0);
    @(negedge clk); #1;
    checks++;
    if (mem_oe !== 1'b0 || mem_addr !== 25'h0 || sram_we !== 1'b0 || sram_oe !== 1'b0) begin
      failures++;
      $display("FAIL in_reset: mem_oe=%b mem_addr=%h sram_we=%b sram_oe=%b required all 0",
               mem_oe, mem_addr, sram_we, sram_oe);
    end
    @(negedge clk); reset = 1'b0;
    set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h00000 || mem_oe !== 1'b1) begin
      failures++; $display("FAIL konami_rd_4000: got %h/%b required 00000/1", mem_addr, mem_oe);
    end
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h6000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h02000 || mem_oe !== 1'b1) begin
      failures++; $display("FAIL konami_rd_6000: got %h/%b required 02000/1", mem_addr, mem_oe);
    end
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'hA000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h06000 || mem_oe !== 1'b1) begin
      failures++; $display("FAIL konami_rd_a000: got %h/%b required 06000/1", mem_addr, mem_oe);
    end
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'hC000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0 || mem_oe !== 1'b0) begin
      failures++; $display("FAIL out_of_range: got %h/%b required 00000/0", mem_addr, mem_oe);
    end
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b1, 16'h6000, 8'h0); #1;
    checks++;
    if (mem_oe !== 1'b0) begin
      failures++; $display("FAIL no_cs: mem_oe=%b required 0", mem_oe);
    end
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_konami;
    cpu_write(16'h5000, 8'h09);
    cpu_write(16'h4000, 8'h0F);
    cpu_write(16'h8000, 8'h04);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h00000) begin
      failures++; $display("FAIL konami_b0_fixed: got %h required 00000", mem_addr);
    end
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h8000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h08000) begin
      failures++; $display("FAIL konami_b2_write: got %h required 08000", mem_addr);
    end
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_ascii8_held;
    change_mode(2'd2);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h6000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0) begin
      failures++; $display("FAIL ascii8_b1_reset: got %h required 00000", mem_addr);
    end
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h8000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0) begin
      failures++; $display("FAIL ascii8_b2_reset: got %h required 00000", mem_addr);
    end
    // wr held four cycles; data changes after the first so a repeat event would show
    @(negedge clk); set_bus(1'b1, 1'b1, 1'b0, 16'h6800, 8'h05);
    @(negedge clk); d_from_cpu = 8'h09;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h6000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0A000 || mem_oe !== 1'b1) begin
      failures++; $display("FAIL held_wr_single: got %h/%b required 0a000/1", mem_addr, mem_oe);
    end
    cpu_write(16'h7800, 8'h02);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'hA000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h04000) begin
      failures++; $display("FAIL ascii8_b3: got %h required 04000", mem_addr);
    end
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_sram;
    cpu_write(16'h7000, 8'h81);
    cpu_write(16'h6000, 8'h81);
    @(negedge clk); set_bus(1'b1, 1'b1, 1'b0, 16'h8010, 8'h5A); #1;
    checks++;
`ifdef CART_BANK_SRAM_EN
    if (sram_we !== 1'b1 || sram_addr !== 15'h2010 || mem_oe !== 1'b0) begin
      failures++;
      $display("FAIL sram_write: we=%b addr=%h mem_oe=%b required 1/2010/0",
               sram_we, sram_addr, mem_oe);
    end
`else
    if (sram_we !== 1'b0 || sram_addr !== 15'h0 || mem_oe !== 1'b0) begin
      failures++;
      $display("FAIL sram_tied: we=%b addr=%h mem_oe=%b required 0/0000/0",
               sram_we, sram_addr, mem_oe);
    end
`endif
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h8010, 8'h0); #1;
    checks++;
`ifdef CART_BANK_SRAM_EN
    if (mem_oe !== 1'b0 || sram_oe !== 1'b1) begin
      failures++; $display("FAIL sram_read: mem_oe=%b sram_oe=%b required 0/1", mem_oe, sram_oe);
    end
`else
    if (mem_oe !== 1'b1 || sram_oe !== 1'b0 || mem_addr !== 25'h02010) begin
      failures++;
      $display("FAIL bit7_ordinary: mem_oe=%b sram_oe=%b mem_addr=%h required 1/0/02010",
               mem_oe, sram_oe, mem_addr);
    end
`endif
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk); set_bus(1'b1, 1'b1, 1'b0, 16'h4010, 8'h5A); #1;
    checks++;
    if (sram_we !== 1'b0) begin
      failures++; $display("FAIL sram_low_page_ro: sram_we=%b required 0", sram_we);
    end
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_ascii16_wrap;
    apply_reset(2'd3, 25'h10000);
    cpu_write(16'h7000, 8'h07);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h8000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0C000 || mem_oe !== 1'b1) begin
      failures++; $display("FAIL ascii16_wrap: got %h/%b required 0c000/1", mem_addr, mem_oe);
    end
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'hBFFF, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0FFFF) begin
      failures++; $display("FAIL ascii16_top: got %h required 0ffff", mem_addr);
    end
    cpu_write(16'h6800, 8'h02);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0) begin
      failures++; $display("FAIL ascii16_bad_window: got %h required 00000", mem_addr);
    end
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_mode_switch;
    logic [15:0] pages [4];
    pages = '{16'h4000, 16'h6000, 16'h8000, 16'hA000};
    change_mode(2'd1);
    cpu_write(16'h9000, 8'h05);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h8000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0A000) begin
      failures++; $display("FAIL scc_b2: got %h required 0a000", mem_addr);
    end
    cpu_write(16'h5000, 8'h06);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0C000) begin
      failures++; $display("FAIL scc_b0: got %h required 0c000", mem_addr);
    end
    // write issued in the same cycle as the mode change must be lost
    @(negedge clk); mode = 2'd2; set_bus(1'b1, 1'b1, 1'b0, 16'h6000, 8'h22);
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, pages[i], 8'h0); #1;
      checks++;
      if (mem_addr !== 25'h0) begin
        failures++;
        $display("FAIL switch_bank%0d: got %h required 00000", i, mem_addr);
      end
    end
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_reset_mid_strobe;
    cpu_write(16'h6000, 8'h05);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0A000) begin
      failures++; $display("FAIL pre_reset_b0: got %h required 0a000", mem_addr);
    end
    @(negedge clk); rom_size = 25'h8000; reset = 1'b1;
    set_bus(1'b1, 1'b1, 1'b0, 16'h6800, 8'h03);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0) begin
      failures++; $display("FAIL post_reset_b0: got %h required 00000", mem_addr);
    end
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h6000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h0) begin
      failures++; $display("FAIL no_event_after_reset: got %h required 00000", mem_addr);
    end
    cpu_write(16'h6000, 8'h05);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h02000) begin
      failures++; $display("FAIL mask_reload_32k: got %h required 02000", mem_addr);
    end
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_small_rom;
    @(negedge clk); rom_size = 25'h1000;
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4000, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h02000) begin
      failures++; $display("FAIL mask_held_no_reset: got %h required 02000", mem_addr);
    end
    apply_reset(2'd2, 25'h1000);
    cpu_write(16'h6000, 8'h05);
    @(negedge clk); set_bus(1'b1, 1'b0, 1'b1, 16'h4123, 8'h0); #1;
    checks++;
    if (mem_addr !== 25'h00123) begin
      failures++; $display("FAIL min_mask_8k: got %h required 00123", mem_addr);
    end
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; mode = 2'd0; rom_size = 25'h0;
    set_bus(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    test_reset();
    test_konami();
    test_ascii8_held();
    test_sram();
    test_ascii16_wrap();
    test_mode_switch();
    test_reset_mid_strobe();
    test_small_rom();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
